dmem_arbiter: RTL and testbench

- Shares the single-port data memory between two requesters.
  - Port A: the pipeline's memory-access stage.
  - Port B: the loader/debug port.
- Issues one access at a time to a memory with 1-cycle synchronous read latency.
- Holds each requester in a req/ack handshake until its access completes.
- Sits between the MA stage and the data memory macro.
- Port A has priority; a starvation counter guarantees Port B forward progress.

---
 rtl/dmem_arbiter_pkg.sv | 18 +
 rtl/dmem_arb_prio.sv | 40 ++++
 rtl/dmem_arbiter.sv | 149 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared constants for the data-memory arbiter: default depth, FSM states, owner encoding.
package dmem_arbiter_pkg;

    localparam int DMEM_SIZE_DFLT = 1024;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RESP = 2'd2,
        ACK  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_t;

endpackage

// File: rtl/dmem_arb_prio.sv
// Winner select for the data-memory arbiter: Port A first, Port B forced after
// STARVE_LIMIT consecutive A grants taken while B was waiting.
module dmem_arb_prio
    import dmem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic arb_en,
    input  logic a_req,
    input  logic b_req,
    output logic grant,
    output logic win_b
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;

    always_comb begin
        grant = a_req | b_req;
        win_b = b_req & (~a_req | (starve_cnt == LIMIT));
    end

    // Only arbitration cycles move the counter; a waiting B keeps it climbing.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            starve_cnt <= '0;
        end else if (arb_en) begin
            if (!b_req || win_b) begin
                starve_cnt <= '0;
            end else if (a_req && (starve_cnt != LIMIT)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port req/ack arbiter in front of a single-port data memory with 1-cycle read latency.
// Optional out-of-range trapping is enabled by defining DMEM_ARB_ADDR_CHECK_EN.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int DMEM_SIZE    = DMEM_SIZE_DFLT,
    parameter int ADDR_W       = $clog2(DMEM_SIZE),
    parameter int STARVE_LIMIT = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [31:0]       a_addr,
    input  logic [31:0]       a_wdata,
    output logic [31:0]       a_rdata,
    output logic              a_ack,
    output logic              a_err,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [31:0]       b_addr,
    input  logic [31:0]       b_wdata,
    output logic [31:0]       b_rdata,
    output logic              b_ack,
    output logic              b_err,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_wdata,
    input  logic [31:0]       m_rdata
);

    state_t      state;
    owner_t      owner;
    logic        cmd_we;
    logic        cmd_err;
    logic        grant;
    logic        win_b;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_bad;

    dmem_arb_prio #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_prio (
        .CLK   (CLK),
        .RST   (RST),
        .arb_en(state == IDLE),
        .a_req (a_req),
        .b_req (b_req),
        .grant (grant),
        .win_b (win_b)
    );

    always_comb begin
        sel_we    = a_we;
        sel_addr  = a_addr;
        sel_wdata = a_wdata;
        if (win_b) begin
            sel_we    = b_we;
            sel_addr  = b_addr;
            sel_wdata = b_wdata;
        end
    end

`ifdef DMEM_ARB_ADDR_CHECK_EN
    assign sel_bad = (sel_addr >= 32'(DMEM_SIZE));
`else
    // Without the check the upper address bits are simply dropped (wrap-around).
    logic unused_addr_hi;
    assign sel_bad        = 1'b0;
    assign unused_addr_hi = ^{a_addr[31:ADDR_W], b_addr[31:ADDR_W]};
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= IDLE;
            owner   <= OWN_A;
            cmd_we  <= 1'b0;
            cmd_err <= 1'b0;
            m_en    <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            a_ack   <= 1'b0;
            a_err   <= 1'b0;
            a_rdata <= '0;
            b_ack   <= 1'b0;
            b_err   <= 1'b0;
            b_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        owner   <= win_b ? OWN_B : OWN_A;
                        cmd_we  <= sel_we;
                        cmd_err <= sel_bad;
                        if (sel_bad) begin
                            // Trapped access never touches the memory.
                            state <= RESP;
                        end else begin
                            state   <= CMD;
                            m_en    <= 1'b1;
                            m_we    <= sel_we;
                            m_addr  <= sel_addr[ADDR_W-1:0];
                            m_wdata <= sel_wdata;
                        end
                    end
                end
                CMD: begin
                    m_en  <= 1'b0;
                    m_we  <= 1'b0;
                    state <= RESP;
                end
                RESP: begin
                    state <= ACK;
                    if (owner == OWN_B) begin
                        b_ack <= 1'b1;
                        b_err <= cmd_err;
                        if (cmd_err) begin
                            b_rdata <= '0;
                        end else if (!cmd_we) begin
                            b_rdata <= m_rdata;
                        end
                    end else begin
                        a_ack <= 1'b1;
                        a_err <= cmd_err;
                        if (cmd_err) begin
                            a_rdata <= '0;
                        end else if (!cmd_we) begin
                            a_rdata <= m_rdata;
                        end
                    end
                end
                ACK: begin
                    // Requests are deliberately ignored here so a held req is not re-granted.
                    a_ack <= 1'b0;
                    a_err <= 1'b0;
                    b_ack <= 1'b0;
                    b_err <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: requester tasks push expected responses from a
// word-level memory model; a negedge monitor pops and compares on every ack and grant.
`timescale 1ns/1ps
module tb_dmem_arbiter;

    localparam int DEPTH = 1024;
    localparam int LIMIT = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        a_req = 1'b0, a_we = 1'b0;
    logic [31:0] a_addr = '0, a_wdata = '0;
    logic [31:0] a_rdata;
    logic        a_ack, a_err;
    logic        b_req = 1'b0, b_we = 1'b0;
    logic [31:0] b_addr = '0, b_wdata = '0;
    logic [31:0] b_rdata;
    logic        b_ack, b_err;
    logic        m_en, m_we;
    logic [9:0]  m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata = '0;

    dmem_arbiter #(
        .DMEM_SIZE   (DEPTH),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .CLK(CLK), .RST(RST),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(a_rdata), .a_ack(a_ack), .a_err(a_err),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rdata(b_rdata), .b_ack(b_ack), .b_err(b_err),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Environment memory: synchronous single port, plus a clear and a preload path.
    logic [31:0] mem [DEPTH];
    logic        mem_clr = 1'b0, pl_en = 1'b0;
    logic [9:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;
    always @(posedge CLK) begin
        if (mem_clr) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
        end else if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (m_en && m_we) begin
            mem[m_addr] <= m_wdata;
        end
        if (m_en && !m_we) m_rdata <= mem[m_addr];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: word array plus the last read value each port should show.
    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [31:0] issue;
        logic [7:0]  lat;
    } exp_t;

    logic [31:0] ref_mem [DEPTH];
    logic [31:0] a_last = '0, b_last = '0;
    exp_t        qa[$], qb[$];
    bit          gq[$];
    int          men_cnt = 0;
    logic [9:0]  last_maddr = '0;

    function automatic exp_t model_access(input bit pb, input logic we, input logic [31:0] addr,
                                          input logic [31:0] wdata, input int issue, input bit timed);
        exp_t e;
        logic [31:0] last;
        last    = pb ? b_last : a_last;
        e.issue = issue;
        e.err   = 1'b0;
        e.lat   = timed ? 8'd3 : 8'd0;
        e.rdata = last;
`ifdef DMEM_ARB_ADDR_CHECK_EN
        if (addr >= 32'(DEPTH)) begin
            e.err   = 1'b1;
            e.rdata = '0;
            if (timed) e.lat = 8'd2;
        end else
`endif
        begin
            if (we) ref_mem[addr[9:0]] = wdata;
            else    e.rdata = ref_mem[addr[9:0]];
        end
        if (pb) b_last = e.rdata;
        else    a_last = e.rdata;
        return e;
    endfunction

    task automatic access(input bit pb, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit keep, input bit timed);
        exp_t e;
        int   n;
        if (pb) begin
            b_we = we; b_addr = addr; b_wdata = wdata; b_req = 1'b1;
        end else begin
            a_we = we; a_addr = addr; a_wdata = wdata; a_req = 1'b1;
        end
        e = model_access(pb, we, addr, wdata, cyc, timed);
        if (pb) qb.push_back(e);
        else    qa.push_back(e);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!(pb ? b_ack : a_ack) && n < 60);
        if (!(pb ? b_ack : a_ack)) chk(pb ? "b_ack_timeout" : "a_ack_timeout", 32'd0, 32'd1);
        @(posedge CLK); #1;
        if (!keep) begin
            if (pb) b_req = 1'b0;
            else    a_req = 1'b0;
        end
    endtask

    task automatic rand_port(input bit pb, input int nops);
        for (int i = 0; i < nops; i++) begin
            logic [31:0] ad;
            int gap;
            ad = pb ? 32'($urandom_range(512, 1023)) : 32'($urandom_range(0, 511));
            if ($urandom_range(0, 7) == 0) ad = ad + 32'd1024;
            gap = (i == nops - 1) ? 1 : int'($urandom_range(0, 3));
            access(pb, 1'($urandom_range(0, 1)), ad, $urandom, gap == 0, 1'b0);
            repeat (gap) begin @(posedge CLK); #1; end
        end
    endtask

    task automatic preload(input logic [9:0] ad, input logic [31:0] d);
        pl_en = 1'b1; pl_addr = ad; pl_data = d;
        @(posedge CLK); #1;
        pl_en = 1'b0;
        ref_mem[ad] = d;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_m_en"}, 32'(m_en), 32'd0);
        chk({tag, "_m_we"}, 32'(m_we), 32'd0);
        chk({tag, "_m_addr"}, 32'(m_addr), 32'd0);
        chk({tag, "_m_wdata"}, m_wdata, 32'd0);
        chk({tag, "_acks"}, {30'd0, a_ack, b_ack}, 32'd0);
        chk({tag, "_errs"}, {30'd0, a_err, b_err}, 32'd0);
        chk({tag, "_a_rdata"}, a_rdata, 32'd0);
        chk({tag, "_b_rdata"}, b_rdata, 32'd0);
    endtask

    // Monitor: every ack pops its port's scoreboard; every memory command checks grant order.
    always @(negedge CLK) begin : mon
        exp_t e;
        bit   g;
        if (RST) begin
            if (a_ack) begin
                if (qa.size() == 0) chk("a_ack_unexpected", 32'd1, 32'd0);
                else begin
                    e = qa.pop_front();
                    chk("a_rdata", a_rdata, e.rdata);
                    chk("a_err", 32'(a_err), 32'(e.err));
                    if (e.lat != 0) chk("a_latency", 32'(cyc) - e.issue, 32'(e.lat));
                end
            end
            if (b_ack) begin
                if (qb.size() == 0) chk("b_ack_unexpected", 32'd1, 32'd0);
                else begin
                    e = qb.pop_front();
                    chk("b_rdata", b_rdata, e.rdata);
                    chk("b_err", 32'(b_err), 32'(e.err));
                    if (e.lat != 0) chk("b_latency", 32'(cyc) - e.issue, 32'(e.lat));
                end
            end
            if (a_ack && b_ack) chk("double_ack", 32'd1, 32'd0);
            if ((a_err && !a_ack) || (b_err && !b_ack)) chk("err_without_ack", 32'd1, 32'd0);
            if (m_en) begin
                men_cnt++;
                last_maddr = m_addr;
                if (gq.size() != 0) begin
                    g = gq.pop_front();
                    chk("grant_owner", 32'(m_addr[9]), 32'(g));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int c0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
        mem_clr = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        mem_clr = 1'b0;
        chk_all_zero("reset");
        RST = 1'b1;
        @(posedge CLK); #1;
        chk("idle_no_req_m_en", 32'(m_en), 32'd0);

        // Single A read.
        preload(10'd5, 32'hDEAD_BEEF);
        c0 = men_cnt;
        access(1'b0, 1'b0, 32'd5, 32'd0, 1'b0, 1'b1);
        chk("a_read_men_pulses", 32'(men_cnt - c0), 32'd1);
        chk("a_read_maddr", 32'(last_maddr), 32'd5);

        // B write then B read of the same word.
        access(1'b1, 1'b1, 32'd9, 32'h0000_1234, 1'b0, 1'b1);
        access(1'b1, 1'b0, 32'd9, 32'd0, 1'b0, 1'b1);
        chk("b_rdata_after_rd", b_rdata, 32'h0000_1234);
        chk("a_rdata_unchanged", a_rdata, 32'hDEAD_BEEF);

        // Starvation: both held high, expected grants A,A,A,A,B,A,A,A,A,B.
        for (int i = 0; i < 10; i++) gq.push_back(i == 4 || i == 9);
        fork
            for (int i = 0; i < 8; i++)
                access(1'b0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 511)), $urandom, i < 7, 1'b0);
            for (int i = 0; i < 2; i++)
                access(1'b1, 1'($urandom_range(0, 1)), 32'($urandom_range(512, 1023)), $urandom, i < 1, 1'b0);
        join
        chk("grant_seq_done", 32'(gq.size()), 32'd0);

        // Reset asserted during CMD of a B write to addr 3.
        preload(10'd3, 32'h5A5A_0003);
        b_we = 1'b1; b_addr = 32'd3; b_wdata = 32'hFFFF_EEEE; b_req = 1'b1;
        @(posedge CLK); #1;
        chk("cmd_before_rst_m_en", 32'(m_en), 32'd1);
        RST = 1'b0;
        #1;
        chk_all_zero("midrst");
        b_req = 1'b0; b_we = 1'b0;
        a_last = '0; b_last = '0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        chk("rst_mem3_kept", mem[3], 32'h5A5A_0003);
        access(1'b1, 1'b0, 32'd3, 32'd0, 1'b0, 1'b1);

        // Out-of-range address, read and write.
        c0 = men_cnt;
        access(1'b0, 1'b0, 32'd1024, 32'd0, 1'b0, 1'b1);
`ifdef DMEM_ARB_ADDR_CHECK_EN
        chk("range_rd_men", 32'(men_cnt - c0), 32'd0);
`else
        chk("range_rd_men", 32'(men_cnt - c0), 32'd1);
        chk("range_rd_maddr", 32'(last_maddr), 32'd0);
`endif
        access(1'b0, 1'b1, 32'd1030, 32'hABCD_0006, 1'b0, 1'b1);
        access(1'b0, 1'b0, 32'd6, 32'd0, 1'b0, 1'b1);

        // Randomized concurrent traffic, A and B in disjoint halves of the memory.
        fork
            rand_port(1'b0, 30);
            rand_port(1'b1, 30);
        join
        repeat (5) @(posedge CLK);
        #1;
        chk("qa_drained", 32'(qa.size()), 32'd0);
        chk("qb_drained", 32'(qb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
